fetch_queue: RTL and testbench

- Instruction-fetch stage directly downstream of the PC register.
- Owns the fetch address counter: loads it from the PC's 32-bit output on redirect, otherwise increments by 4 per accepted memory request.
- Issues pipelined read requests to instruction memory and buffers returned words with their addresses in an in-order queue for decode.
- Drops responses that belong to requests made before a redirect (stale responses).

---
 rtl/fetch_queue.sv | 107 ++++++++++
 tb/tb_fetch_queue.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue: instruction-fetch stage sitting just after the PC register.
// It owns the fetch address and issues pipelined reads to instruction memory.
// Returned words are buffered in order, together with their addresses, for decode.
// Responses to requests issued before a redirect are counted and thrown away.
module fetch_queue #(
    parameter int                 ADDR_W   = 32,
    parameter int                 DEPTH    = 4,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              redirect,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [ADDR_W-1:0] mem_rdata,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] inst_out,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              inst_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW:0]       DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(4);

    logic [ADDR_W-1:0] data_q [DEPTH];
    logic [ADDR_W-1:0] pc_q   [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     drop_cnt;
    logic [ADDR_W-1:0] fetch_pc;
    logic [ADDR_W-1:0] resp_pc;

    logic [CW:0] occupancy;
    logic        accept;
    logic        rsp;
    logic        push;
    logic        pop;

    assign occupancy = {1'b0, count} + {1'b0, outstanding};

    // A request is only offered while a queue slot is guaranteed for its response.
    assign mem_req  = !reset && !redirect && (occupancy < DEPTH_C);
    assign mem_addr = fetch_pc;
    assign accept   = mem_req && mem_ready;

    // A response with nothing in flight is a leftover from before a reset, so it is ignored.
    assign rsp  = mem_rvalid && (outstanding != '0);
    assign push = rsp && !redirect && (drop_cnt == '0);
    assign pop  = inst_valid && inst_ready;

    assign inst_valid = (count != '0);
    assign inst_out   = inst_valid ? data_q[head] : '0;
    assign inst_pc    = inst_valid ? pc_q[head]   : '0;

    // Control state: fetch address, response address, queue pointers and the credit counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else if (redirect) begin
            fetch_pc    <= pc_in;
            resp_pc     <= pc_in;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= outstanding - CW'(rsp);
            drop_cnt    <= outstanding - CW'(rsp);
        end else begin
            if (accept) begin
                fetch_pc <= fetch_pc + STEP;
            end
            outstanding <= outstanding + CW'(accept) - CW'(rsp);
            if (rsp && (drop_cnt != '0)) begin
                drop_cnt <= drop_cnt - CW'(1);
            end
            if (push) begin
                tail    <= tail + PW'(1);
                resp_pc <= resp_pc + STEP;
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Queue storage; contents past the tail are don't-care, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (!reset && push) begin
            data_q[tail] <= mem_rdata;
            pc_q[tail]   <= resp_pc;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed test of fetch_queue against a fixed-latency memory model.
// The memory model returns rdata = addr + 0x100 in request order.
module tb_fetch_queue;

    logic        clk;
    logic        reset;
    logic [31:0] pc_in;
    logic        redirect;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_ready;

    int checks = 0;
    int errors = 0;
    int mem_lat = 1;
    int edge_n = 0;

    typedef struct {
        int          due;
        logic [31:0] addr;
    } pend_t;
    pend_t pend_q[$];

    fetch_queue #(.ADDR_W(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk        (clk),
        .reset      (reset),
        .pc_in      (pc_in),
        .redirect   (redirect),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .inst_valid (inst_valid),
        .inst_out   (inst_out),
        .inst_pc    (inst_pc),
        .inst_ready (inst_ready)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: records accepts at the edge and presents the due response 2 time units later.
    initial begin
        pend_t p;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(posedge clk);
            edge_n++;
            if (mem_rvalid && pend_q.size() > 0) begin
                void'(pend_q.pop_front());
            end
            if (mem_req && mem_ready) begin
                p.due  = edge_n + mem_lat;
                p.addr = mem_addr;
                pend_q.push_back(p);
            end
            #2;
            if (pend_q.size() > 0 && pend_q[0].due == edge_n + 1) begin
                mem_rvalid = 1'b1;
                mem_rdata  = pend_q[0].addr + 32'h100;
            end else begin
                mem_rvalid = 1'b0;
                mem_rdata  = '0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #4;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) tick();
        check_output("rst_mem_req",    32'(mem_req),    32'h0);
        check_output("rst_inst_valid", 32'(inst_valid), 32'h0);
        check_output("rst_inst_out",   inst_out,        32'h0);
        check_output("rst_inst_pc",    inst_pc,         32'h0);
        check_output("rst_mem_addr",   mem_addr,        32'h0);
        reset = 1'b0;
        #1;
    endtask

    // Directed sequence covering streaming, backpressure, redirects, reset and address wrap.
    initial begin
        reset      = 1'b1;
        redirect   = 1'b0;
        pc_in      = '0;
        mem_ready  = 1'b1;
        inst_ready = 1'b1;

        $display("[TB] test 1: streaming after reset");
        apply_reset(5);
        check_output("t1_req0",   32'(mem_req), 32'h1);
        check_output("t1_addr0",  mem_addr,     32'h0);
        tick();
        check_output("t1_addr1",  mem_addr,     32'h4);
        check_output("t1_valid1", 32'(inst_valid), 32'h0);
        tick();
        check_output("t1_addr2",  mem_addr,     32'h8);
        check_output("t1_valid2", 32'(inst_valid), 32'h1);
        check_output("t1_pc0",    inst_pc,      32'h0);
        check_output("t1_out0",   inst_out,     32'h100);
        tick();
        check_output("t1_pc1",    inst_pc,      32'h4);
        check_output("t1_out1",   inst_out,     32'h104);
        tick();
        check_output("t1_pc2",    inst_pc,      32'h8);
        check_output("t1_out2",   inst_out,     32'h108);
        check_output("t1_addr4",  mem_addr,     32'h10);

        $display("[TB] test 2: consumer stalled, credit limit");
        inst_ready = 1'b0;
        apply_reset(4);
        for (int i = 0; i < 4; i++) begin
            check_output("t2_req",  32'(mem_req), 32'h1);
            check_output("t2_addr", mem_addr,     32'(4 * i));
            tick();
        end
        check_output("t2_full_req",   32'(mem_req),    32'h0);
        check_output("t2_full_valid", 32'(inst_valid), 32'h1);
        check_output("t2_hold_pc",    inst_pc,         32'h0);
        check_output("t2_hold_out",   inst_out,        32'h100);
        tick();
        check_output("t2_full_req5",  32'(mem_req),    32'h0);
        tick();
        check_output("t2_full_req6",  32'(mem_req),    32'h0);
        check_output("t2_hold_pc6",   inst_pc,         32'h0);
        inst_ready = 1'b1;
        #1;
        tick();
        check_output("t2_pop_pc1",    inst_pc,         32'h4);
        check_output("t2_resume_req", 32'(mem_req),    32'h1);
        check_output("t2_resume_addr", mem_addr,       32'h10);
        tick();
        check_output("t2_pop_pc2",    inst_pc,         32'h8);
        check_output("t2_addr_14",    mem_addr,        32'h14);
        tick();
        check_output("t2_pop_pc3",    inst_pc,         32'hC);
        tick();
        check_output("t2_pop_pc4",    inst_pc,         32'h10);
        check_output("t2_pop_out4",   inst_out,        32'h110);

        $display("[TB] test 3: redirect with two requests in flight");
        apply_reset(4);
        mem_lat = 3;
        check_output("t3_addr0", mem_addr, 32'h0);
        tick();
        check_output("t3_addr1", mem_addr, 32'h4);
        tick();
        redirect = 1'b1;
        pc_in    = 32'h40;
        #1;
        check_output("t3_redir_req", 32'(mem_req), 32'h0);
        tick();
        redirect = 1'b0;
        #1;
        check_output("t3_new_req",   32'(mem_req),    32'h1);
        check_output("t3_new_addr",  mem_addr,        32'h40);
        check_output("t3_valid_a",   32'(inst_valid), 32'h0);
        tick();
        check_output("t3_addr_44",   mem_addr,        32'h44);
        check_output("t3_valid_b",   32'(inst_valid), 32'h0);
        tick();
        check_output("t3_valid_c",   32'(inst_valid), 32'h0);
        tick();
        check_output("t3_valid_d",   32'(inst_valid), 32'h0);
        tick();
        check_output("t3_first_valid", 32'(inst_valid), 32'h1);
        check_output("t3_first_pc",    inst_pc,         32'h40);
        check_output("t3_first_out",   inst_out,        32'h140);

        $display("[TB] test 4: redirect with same-cycle response and pop");
        apply_reset(4);
        mem_lat = 1;
        check_output("t4_addr0", mem_addr, 32'h0);
        tick();
        tick();
        check_output("t4_valid_pre",  32'(inst_valid), 32'h1);
        check_output("t4_rvalid_pre", 32'(mem_rvalid), 32'h1);
        redirect = 1'b1;
        pc_in    = 32'h200;
        #1;
        check_output("t4_redir_req", 32'(mem_req), 32'h0);
        tick();
        redirect = 1'b0;
        #1;
        check_output("t4_flushed",   32'(inst_valid), 32'h0);
        check_output("t4_new_addr",  mem_addr,        32'h200);
        check_output("t4_new_req",   32'(mem_req),    32'h1);
        tick();
        check_output("t4_valid_b",   32'(inst_valid), 32'h0);
        tick();
        check_output("t4_first_valid", 32'(inst_valid), 32'h1);
        check_output("t4_first_pc",    inst_pc,         32'h200);
        check_output("t4_first_out",   inst_out,        32'h300);

        $display("[TB] test 5: reset mid-stream");
        inst_ready = 1'b0;
        apply_reset(4);
        repeat (4) tick();
        check_output("t5_pre_valid", 32'(inst_valid), 32'h1);
        check_output("t5_pre_req",   32'(mem_req),    32'h0);
        reset = 1'b1;
        #1;
        tick();
        check_output("t5_rst_valid", 32'(inst_valid), 32'h0);
        check_output("t5_rst_addr",  mem_addr,        32'h0);
        check_output("t5_rst_pc",    inst_pc,         32'h0);
        check_output("t5_rst_out",   inst_out,        32'h0);
        reset      = 1'b0;
        inst_ready = 1'b1;
        #1;
        check_output("t5_restart_req", 32'(mem_req), 32'h1);
        tick();
        check_output("t5_valid_b",   32'(inst_valid), 32'h0);
        tick();
        check_output("t5_first_valid", 32'(inst_valid), 32'h1);
        check_output("t5_first_pc",    inst_pc,         32'h0);
        check_output("t5_first_out",   inst_out,        32'h100);

        $display("[TB] test 6: back-to-back redirects and address wrap");
        apply_reset(4);
        redirect = 1'b1;
        pc_in    = 32'h500;
        #1;
        check_output("t6_redir1_req", 32'(mem_req), 32'h0);
        tick();
        pc_in = 32'hFFFF_FFFC;
        #1;
        check_output("t6_redir2_req",  32'(mem_req), 32'h0);
        check_output("t6_redir1_addr", mem_addr,     32'h500);
        tick();
        redirect = 1'b0;
        #1;
        check_output("t6_addr_top",  mem_addr,     32'hFFFF_FFFC);
        check_output("t6_req_top",   32'(mem_req), 32'h1);
        tick();
        check_output("t6_addr_wrap", mem_addr,     32'h0);
        tick();
        check_output("t6_valid_top", 32'(inst_valid), 32'h1);
        check_output("t6_pc_top",    inst_pc,         32'hFFFF_FFFC);
        check_output("t6_out_top",   inst_out,        32'h0000_00FC);
        tick();
        check_output("t6_pc_wrap",   inst_pc,         32'h0);
        check_output("t6_out_wrap",  inst_out,        32'h100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
